// File: rtl/handshake_fifo_pkg.sv
// rtl/handshake_fifo_pkg.sv - shared defaults and width helpers for the handshake result FIFO
package handshake_fifo_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 4;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointers wrap by natural overflow, so the depth must be a power of two.
   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// rtl/handshake_fifo_mem.sv - WIDTH x DEPTH register array, synchronous write, asynchronous read
module handshake_fifo_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/handshake_result_fifo.sv
// rtl/handshake_result_fifo.sv - elastic valid/ready FIFO for the result channel
// Optional zero-latency pass-through when empty: HANDSHAKE_RESULT_FIFO_BYPASS_EN.
module handshake_result_fifo
   import handshake_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int AW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("handshake_result_fifo: DEPTH must be a power of two >= 2");
   end

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_rdata;
   logic             empty, full, push, pop, wr_en, rd_en;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign in_ready = !reset && !full;
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign count    = count_q;

`ifdef HANDSHAKE_RESULT_FIFO_BYPASS_EN
   logic pass_through;
   // A word consumed in the same cycle it arrives at an empty FIFO never touches storage.
   assign pass_through = empty && in_valid && out_ready && !reset;
   assign out_valid    = !reset && (!empty || in_valid);
   assign out_data     = empty ? in_data : mem_rdata;
   assign wr_en        = push && !pass_through;
   assign rd_en        = pop && !empty;
`else
   assign out_valid = !reset && !empty;
   assign out_data  = mem_rdata;
   assign wr_en     = push;
   assign rd_en     = pop;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
      if (rd_en) rd_ptr_d = AW'(rd_ptr_q + 1'b1);
      case ({wr_en, rd_en})
         2'b10:   count_d = CW'(count_q + 1'b1);
         2'b01:   count_d = CW'(count_q - 1'b1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   handshake_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clock),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

endmodule
